// File: rtl/operand_issuer_pkg.sv
// rtl/operand_issuer_pkg.sv - shared types, defaults and sizing helpers for operand_issuer
// Purpose: state encoding for the issue FSM, default operand width, pointer-width helper.
package operand_issuer_pkg;

  localparam int DEFAULT_DATAWIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Address bits needed for a storage of 'depth' entries (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - circular FIFO holding packed operand triples
// Purpose: storage, read/write pointers and registered occupancy for operand_issuer.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_push_valid, o_ready  push handshake; o_ready decoded from registered count
//   i_push_data            packed triple to store
//   i_pop                  consume the head entry (ignored when empty)
//   o_rd_data              head entry (valid when o_count != 0)
//   o_count                occupancy 0..DEPTH
module operand_fifo
  import operand_issuer_pkg::*;
#(
  parameter int WIDTH = 3 * DEFAULT_DATAWIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full refuses a push even if a pop happens on the same edge (no bypass).
  assign o_ready   = (r_count != FULL_COUNT);
  assign w_push    = i_push_valid && o_ready;
  assign w_pop     = i_pop && (r_count != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is not reset: contents are meaningless once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/operand_issuer.sv
// rtl/operand_issuer.sv - queues signed operand triples and issues each one held for HOLD cycles
// Purpose: back-pressured operand source for the registered datapath circuits.
// Ports:
//   Clk, Rst                clock, asynchronous active-low reset
//   in_valid, in_ready      producer handshake for in_a/in_b/in_c
//   in_a, in_b, in_c        incoming signed operands
//   a, b, c                 registered operands to the datapath
//   issue                   one-cycle pulse when a/b/c take a new triple
//   busy                    high while a triple is being held
//   count                   FIFO occupancy (registered)
module operand_issuer
  import operand_issuer_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int DEPTH     = 4,
  parameter int HOLD      = 2
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATAWIDTH-1:0] in_a,
  input  logic signed [DATAWIDTH-1:0] in_b,
  input  logic signed [DATAWIDTH-1:0] in_c,
  output logic signed [DATAWIDTH-1:0] a,
  output logic signed [DATAWIDTH-1:0] b,
  output logic signed [DATAWIDTH-1:0] c,
  output logic                        issue,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

  state_t                 r_state;
  logic [HW-1:0]          r_hold_cnt;
  logic                   w_pop;
  logic [3*DATAWIDTH-1:0] w_rd_data;
  logic [$clog2(DEPTH):0] w_count;

  operand_fifo #(
    .WIDTH (3 * DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (Clk),
    .i_rst_n      (Rst),
    .i_push_valid (in_valid),
    .o_ready      (in_ready),
    .i_push_data  ({in_a, in_b, in_c}),
    .i_pop        (w_pop),
    .o_rd_data    (w_rd_data),
    .o_count      (w_count)
  );

  assign count = w_count;

  // Pop when idle, or on the last hold edge for a back-to-back reissue.
  assign w_pop = (w_count != '0) &&
                 ((r_state == ST_IDLE) || (r_hold_cnt == '0));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      issue      <= 1'b0;
      busy       <= 1'b0;
    end else if (w_pop) begin
      a          <= w_rd_data[3*DATAWIDTH-1:2*DATAWIDTH];
      b          <= w_rd_data[2*DATAWIDTH-1:DATAWIDTH];
      c          <= w_rd_data[DATAWIDTH-1:0];
      issue      <= 1'b1;
      busy       <= 1'b1;
      r_hold_cnt <= HOLD_LOAD;
      r_state    <= ST_HOLD;
    end else begin
      issue <= 1'b0;
      if (r_state == ST_HOLD) begin
        if (r_hold_cnt == '0) begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end
      end
    end
  end

endmodule
